// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter
//
// Shares one fixed-latency, non-pipelined main-memory port between the I-side and D-side caches.
// A grant covers one whole line: 2^LINE_ADDR_LEN beats, each an ISSUE cycle followed by MEM_LAT
// WAIT cycles. Ties are broken round-robin. Refill words come back beat by beat on rdata, and a
// one-cycle done pulse lets the stalled pipeline resume.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   i_req/d_req              line transfer request, held until done
//   i_we/d_we                1 = writeback, 0 = refill (sampled at grant)
//   i_addr/d_addr            byte address of the line (sampled at grant)
//   i_wdata/d_wdata          write word for the current x_beat
//   i_gnt/d_gnt              transaction owner, ISSUE through DONE
//   i_beat/d_beat            current word index, 0 when not granted
//   i_rvalid/d_rvalid        rdata holds the refill word for x_beat
//   i_done/d_done            one-cycle completion pulse
//   rdata                    shared read return, 0 unless an rvalid is high
//   busy                     arbiter not idle
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory port
module mem_line_arbiter #(
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned MEM_LAT       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req,
  input  logic                     d_req,
  input  logic                     i_we,
  input  logic                     d_we,
  input  logic [31:0]              i_addr,
  input  logic [31:0]              d_addr,
  input  logic [31:0]              i_wdata,
  input  logic [31:0]              d_wdata,
  output logic                     i_gnt,
  output logic                     d_gnt,
  output logic [LINE_ADDR_LEN-1:0] i_beat,
  output logic [LINE_ADDR_LEN-1:0] d_beat,
  output logic                     i_rvalid,
  output logic                     d_rvalid,
  output logic                     i_done,
  output logic                     d_done,
  output logic [31:0]              rdata,
  output logic                     busy,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata
);

  localparam int unsigned BaseW = 30 - LINE_ADDR_LEN;
  localparam int unsigned CntW  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LINE_ADDR_LEN-1:0] LastBeat = '1;
  localparam logic [CntW-1:0]          CntLoad  = CntW'(MEM_LAT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e                   state_q;
  logic                     own_d_q;   // 1: D side owns the current transaction
  logic                     last_d_q;  // 1: D won the last grant
  logic                     we_q;
  logic [BaseW-1:0]         base_q;
  logic [LINE_ADDR_LEN-1:0] beat_q;
  logic [CntW-1:0]          cnt_q;
  logic                     i_gnt_q, d_gnt_q;
  logic [LINE_ADDR_LEN-1:0] i_beat_q, d_beat_q;

  logic win_d;
  logic in_issue;
  logic rd_hit;

  // Word offset bits are ignored; the line base is all that is latched.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[LINE_ADDR_LEN+1:0], d_addr[LINE_ADDR_LEN+1:0]};

  // D wins when alone, or on a tie when I had the previous grant.
  assign win_d = d_req & (~i_req | ~last_d_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      own_d_q  <= 1'b0;
      last_d_q <= 1'b0;
      we_q     <= 1'b0;
      base_q   <= '0;
      beat_q   <= '0;
      cnt_q    <= '0;
      i_gnt_q  <= 1'b0;
      d_gnt_q  <= 1'b0;
      i_beat_q <= '0;
      d_beat_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_req || d_req) begin
            own_d_q  <= win_d;
            last_d_q <= win_d;
            we_q     <= win_d ? d_we : i_we;
            base_q   <= win_d ? d_addr[31:LINE_ADDR_LEN+2] : i_addr[31:LINE_ADDR_LEN+2];
            beat_q   <= '0;
            i_beat_q <= '0;
            d_beat_q <= '0;
            i_gnt_q  <= ~win_d;
            d_gnt_q  <= win_d;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          cnt_q   <= CntLoad;
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q == '0) begin
            if (beat_q == LastBeat) begin
              state_q <= StDone;
            end else begin
              beat_q <= beat_q + LINE_ADDR_LEN'(1);
              if (own_d_q) begin
                d_beat_q <= beat_q + LINE_ADDR_LEN'(1);
              end else begin
                i_beat_q <= beat_q + LINE_ADDR_LEN'(1);
              end
              state_q <= StIssue;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StDone: begin
          i_gnt_q  <= 1'b0;
          d_gnt_q  <= 1'b0;
          beat_q   <= '0;
          i_beat_q <= '0;
          d_beat_q <= '0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Decodes of the state registers; an asynchronous reset clears them at once.
  always_comb begin
    in_issue  = (state_q == StIssue);
    rd_hit    = (state_q == StWait) && (cnt_q == '0) && !we_q;
    i_gnt     = i_gnt_q;
    d_gnt     = d_gnt_q;
    i_beat    = i_beat_q;
    d_beat    = d_beat_q;
    i_rvalid  = rd_hit & ~own_d_q;
    d_rvalid  = rd_hit & own_d_q;
    i_done    = (state_q == StDone) & ~own_d_q;
    d_done    = (state_q == StDone) & own_d_q;
    rdata     = rd_hit ? mem_rdata : '0;
    busy      = (state_q != StIdle);
    mem_en    = in_issue;
    mem_we    = in_issue & we_q;
    mem_addr  = in_issue ? {base_q, beat_q, 2'b00} : '0;
    mem_wdata = (in_issue && we_q) ? (own_d_q ? d_wdata : i_wdata) : '0;
  end

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Bench for mem_line_arbiter: directed scenarios plus randomized request mixes, checked cycle by
// cycle against a timing model derived from beat arithmetic. A second instance runs MEM_LAT = 1.
module tb_mem_line_arbiter;

  localparam int LAL = 3;
  localparam int W   = 8;

  typedef struct packed {
    logic           i_gnt;
    logic           d_gnt;
    logic [LAL-1:0] i_beat;
    logic [LAL-1:0] d_beat;
    logic           i_rvalid;
    logic           d_rvalid;
    logic           i_done;
    logic           d_done;
    logic [31:0]    rdata;
    logic           busy;
    logic           mem_en;
    logic           mem_we;
    logic [31:0]    mem_addr;
    logic [31:0]    mem_wdata;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_req = 1'b0, d_req = 1'b0, i_we = 1'b0, d_we = 1'b0;
  logic i1_req = 1'b0, d1_req = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, i_wpat = '0, d_wpat = '0, zero_w = '0;
  logic [31:0] i_wdata0, d_wdata0, mem_rdata0, mem_rdata1, salt;

  logic i_gnt0, d_gnt0, i_rvalid0, d_rvalid0, i_done0, d_done0, busy0, mem_en0, mem_we0;
  logic [LAL-1:0] i_beat0, d_beat0;
  logic [31:0] rdata0, mem_addr0, mem_wdata0;
  logic i_gnt1, d_gnt1, i_rvalid1, d_rvalid1, i_done1, d_done1, busy1, mem_en1, mem_we1;
  logic [LAL-1:0] i_beat1, d_beat1;
  logic [31:0] rdata1, mem_addr1, mem_wdata1;

  obs_t o0, o1;
  int   vectors = 0, miscompares = 0, cur_t = 0;
  int   cyc = 0, rd0_due = -1, rd1_due = -1;
  logic [31:0] rd0_a = '0, rd1_a = '0;
  bit   last_d = 1'b0;  // reference pointer: 1 when D had the last grant
  bit   first_d;
  int unsigned pat;

  always #5 clk = ~clk;

  assign i_wdata0 = i_wpat + 32'(i_beat0);
  assign d_wdata0 = d_wpat + 32'(d_beat0);

  mem_line_arbiter #(.LINE_ADDR_LEN(LAL), .MEM_LAT(4)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .d_req(d_req), .i_we(i_we), .d_we(d_we),
    .i_addr(i_addr), .d_addr(d_addr), .i_wdata(i_wdata0), .d_wdata(d_wdata0),
    .i_gnt(i_gnt0), .d_gnt(d_gnt0), .i_beat(i_beat0), .d_beat(d_beat0),
    .i_rvalid(i_rvalid0), .d_rvalid(d_rvalid0), .i_done(i_done0), .d_done(d_done0),
    .rdata(rdata0), .busy(busy0), .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
  );

  mem_line_arbiter #(.LINE_ADDR_LEN(LAL), .MEM_LAT(1)) dut_l1 (
    .clk(clk), .rst(rst), .i_req(i1_req), .d_req(d1_req), .i_we(i_we), .d_we(d_we),
    .i_addr(i_addr), .d_addr(d_addr), .i_wdata(zero_w), .d_wdata(zero_w),
    .i_gnt(i_gnt1), .d_gnt(d_gnt1), .i_beat(i_beat1), .d_beat(d_beat1),
    .i_rvalid(i_rvalid1), .d_rvalid(d_rvalid1), .i_done(i_done1), .d_done(d_done1),
    .rdata(rdata1), .busy(busy1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  assign o0 = {i_gnt0, d_gnt0, i_beat0, d_beat0, i_rvalid0, d_rvalid0, i_done0, d_done0,
               rdata0, busy0, mem_en0, mem_we0, mem_addr0, mem_wdata0};
  assign o1 = {i_gnt1, d_gnt1, i_beat1, d_beat1, i_rvalid1, d_rvalid1, i_done1, d_done1,
               rdata1, busy1, mem_en1, mem_we1, mem_addr1, mem_wdata1};

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ salt;
  endfunction

  // Memory: read data is driven only in the exact cycle it is due, junk otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en0 && !mem_we0) begin
      rd0_a   <= mem_addr0;
      rd0_due <= cyc + 4;
    end
    if (mem_en1 && !mem_we1) begin
      rd1_a   <= mem_addr1;
      rd1_due <= cyc + 1;
    end
  end

  always_comb begin
    mem_rdata0 = (cyc == rd0_due) ? word(rd0_a) : 32'hDEAD_BEEF;
    mem_rdata1 = (cyc == rd1_due) ? word(rd1_a) : 32'hDEAD_BEEF;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: obs=still running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0d obs=%h exp=%h", tag, cur_t, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string pre, input obs_t o);
    chk({pre, ".i_gnt"}, 32'(o.i_gnt), 0);
    chk({pre, ".d_gnt"}, 32'(o.d_gnt), 0);
    chk({pre, ".beats"}, 32'({o.i_beat, o.d_beat}), 0);
    chk({pre, ".rvalid"}, 32'({o.i_rvalid, o.d_rvalid}), 0);
    chk({pre, ".done"}, 32'({o.i_done, o.d_done}), 0);
    chk({pre, ".rdata"}, o.rdata, 0);
    chk({pre, ".busy"}, 32'(o.busy), 0);
    chk({pre, ".mem_en_we"}, 32'({o.mem_en, o.mem_we}), 0);
    chk({pre, ".mem_addr"}, o.mem_addr, 0);
    chk({pre, ".mem_wdata"}, o.mem_wdata, 0);
  endtask

  task automatic set_req(input bit l1, input bit sd, input logic v);
    if (l1) begin
      if (sd) d1_req = v;
      else    i1_req = v;
    end else begin
      if (sd) d_req = v;
      else    i_req = v;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_req = 1'b0; d_req = 1'b0; i1_req = 1'b0; d1_req = 1'b0;
    step();
    rst = 1'b0;
    last_d = 1'b0;
  endtask

  // Caller raises the owner's request in cycle 0; this checks cycles 1 .. W*(L+1)+2.
  // drop_at: owner drops req; other_at: other side raises req; abort_at: reset pulse.
  task automatic run_txn(input bit l1, input bit sd, input bit we, input logic [31:0] addr,
                         input int drop_at, input int other_at, input int abort_at);
    int L, last, k;
    bit g, iss, rv, dn;
    logic [31:0] base, wp, rd_e;
    obs_t o;
    L    = l1 ? 1 : 4;
    last = W * (L + 1) + 2;
    base = {addr[31:LAL+2], 5'b0};
    wp   = sd ? d_wpat : i_wpat;
    if (!l1) last_d = sd;
    for (int t = 1; t <= last; t++) begin
      step();
      cur_t = t;
      o   = l1 ? o1 : o0;
      g   = (t <= W * (L + 1) + 1);
      k   = (t - 1) / (L + 1);
      if (k > W - 1) k = W - 1;
      iss = ((t - 1) % (L + 1) == 0) && (t <= 1 + (W - 1) * (L + 1));
      rv  = !we && (t % (L + 1) == 0) && (t <= W * (L + 1));
      dn  = (t == W * (L + 1) + 1);
      rd_e = rv ? word(base + 32'(4 * (t / (L + 1) - 1))) : 32'h0;
      chk("own_gnt", 32'(sd ? o.d_gnt : o.i_gnt), 32'(g));
      chk("other_gnt", 32'(sd ? o.i_gnt : o.d_gnt), 0);
      chk("own_beat", 32'(sd ? o.d_beat : o.i_beat), g ? 32'(k) : 0);
      chk("other_beat", 32'(sd ? o.i_beat : o.d_beat), 0);
      chk("own_rvalid", 32'(sd ? o.d_rvalid : o.i_rvalid), 32'(rv));
      chk("other_rvalid", 32'(sd ? o.i_rvalid : o.d_rvalid), 0);
      chk("own_done", 32'(sd ? o.d_done : o.i_done), 32'(dn));
      chk("other_done", 32'(sd ? o.i_done : o.d_done), 0);
      chk("rdata", o.rdata, rd_e);
      chk("busy", 32'(o.busy), 32'(g));
      chk("mem_en", 32'(o.mem_en), 32'(iss));
      chk("mem_we", 32'(o.mem_we), 32'(iss && we));
      chk("mem_addr", o.mem_addr, iss ? base + 32'(4 * k) : 32'h0);
      chk("mem_wdata", o.mem_wdata, (iss && we) ? wp + 32'(k) : 32'h0);
      if (t == abort_at) begin
        rst = 1'b1;
        #1;
        chk_quiet("abort", l1 ? o1 : o0);
        set_req(l1, sd, 1'b0);
        step();
        rst = 1'b0;
        last_d = 1'b0;
        for (int j = 0; j < 6; j++) begin
          step();
          o = l1 ? o1 : o0;
          chk("post_abort_done", 32'({o.i_done, o.d_done}), 0);
          chk("post_abort_busy", 32'(o.busy), 0);
        end
        return;
      end
      if (t == drop_at) set_req(l1, sd, 1'b0);
      if (t == other_at) set_req(l1, !sd, 1'b1);
      if (dn) set_req(l1, sd, 1'b0);
    end
  endtask

  initial begin
    salt   = $urandom;
    i_wpat = $urandom;
    #1;
    cur_t = 0;
    chk_quiet("in_reset0", o0);
    step();
    chk_quiet("in_reset1", o1);
    rst = 1'b0;
    step();
    chk_quiet("idle0", o0);

    // Single D refill, line 0x1040
    d_we = 1'b0; d_addr = 32'h0000_1047; d_req = 1'b1;
    run_txn(1'b0, 1'b1, 1'b0, d_addr, -1, -1, -1);

    // D writeback of line 0x2000
    d_we = 1'b1; d_addr = 32'h0000_2000; d_wpat = 32'hA000_0000; d_req = 1'b1;
    run_txn(1'b0, 1'b1, 1'b1, d_addr, -1, -1, -1);

    // Ties from reset: D, I, then D again
    do_reset();
    d_we = 1'b0; i_we = 1'b1; d_addr = $urandom; i_addr = $urandom;
    i_req = 1'b1; d_req = 1'b1;
    run_txn(1'b0, 1'b1, d_we, d_addr, -1, -1, -1);
    run_txn(1'b0, 1'b0, i_we, i_addr, -1, -1, -1);
    i_we = 1'b0; d_we = 1'b1; d_wpat = $urandom;
    i_req = 1'b1; d_req = 1'b1;
    run_txn(1'b0, 1'b1, d_we, d_addr, -1, -1, -1);
    run_txn(1'b0, 1'b0, i_we, i_addr, -1, -1, -1);

    // I request arrives mid-D transaction and waits
    d_we = 1'b0; d_addr = $urandom; i_addr = $urandom; d_req = 1'b1;
    run_txn(1'b0, 1'b1, d_we, d_addr, -1, 10, -1);
    run_txn(1'b0, 1'b0, i_we, i_addr, -1, -1, -1);

    // Owner drops req at cycle 5
    d_addr = $urandom; d_req = 1'b1;
    run_txn(1'b0, 1'b1, d_we, d_addr, 5, -1, -1);

    // Reset at cycle 20 mid-refill, then a clean restart
    d_addr = $urandom; d_req = 1'b1;
    run_txn(1'b0, 1'b1, d_we, d_addr, -1, -1, 20);
    d_addr = $urandom; d_req = 1'b1;
    run_txn(1'b0, 1'b1, d_we, d_addr, -1, -1, -1);

    // Randomized mixes against the round-robin reference pointer
    for (int n = 0; n < 10; n++) begin
      pat    = $urandom_range(1, 3);
      i_we   = 1'($urandom_range(0, 1));
      d_we   = 1'($urandom_range(0, 1));
      i_addr = $urandom; d_addr = $urandom;
      i_wpat = $urandom; d_wpat = $urandom;
      i_req  = pat[0];
      d_req  = pat[1];
      first_d = (pat == 2) ? 1'b1 : (pat == 1) ? 1'b0 : !last_d;
      run_txn(1'b0, first_d, first_d ? d_we : i_we, first_d ? d_addr : i_addr,
              int'($urandom_range(1, 40)), -1, -1);
      if (pat == 3) begin
        run_txn(1'b0, !first_d, first_d ? i_we : d_we, first_d ? i_addr : d_addr,
                -1, -1, -1);
      end
    end

    // MEM_LAT = 1 instance: DONE at cycle 17
    d_we = 1'b0; d_addr = $urandom; d1_req = 1'b1;
    run_txn(1'b1, 1'b1, 1'b0, d_addr, -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
